// File: rtl/sram_bank_retention_ctrl_if.sv
// Request/grant/response signals between the bus, the retention controller and
// the SRAM bank. Only the request strobe is gated by the controller. Address,
// write enable, write data and byte enables bypass it and are not carried here.
interface sram_bank_retention_ctrl_if;
    logic req_i;       // OBI request from the bus
    logic gnt_o;       // OBI grant back to the bus
    logic rvalid_i;    // response valid from the bank
    logic bank_req_o;  // gated request towards the bank

    // Bus plus bank side: issues requests and returns responses.
    modport master (
        output req_i,
        output rvalid_i,
        input  gnt_o,
        input  bank_req_o
    );

    // Retention controller side.
    modport slave (
        input  req_i,
        input  rvalid_i,
        output gnt_o,
        output bank_req_o
    );
endinterface

// File: rtl/sram_bank_retention_ctrl.sv
// Per-bank retention sequencer. It gates the OBI request to one SRAM bank and
// tracks the single outstanding access. After a programmable idle time, or
// when forced, it drains the bank and puts it into retention. On a new request
// it wakes the bank and stalls the master until exit settling has finished.
module sram_bank_retention_ctrl #(
    parameter int IdleCycles  = 16,
    parameter int EnterCycles = 2,
    parameter int ExitCycles  = 2,
    parameter int CntWidth    = 8
) (
    input  logic                          clk_cg,
    input  logic                          rst_ni,
    input  logic                          ret_en_i,
    input  logic                          force_ret_i,
    sram_bank_retention_ctrl_if.slave     bus,
    output logic                          set_retentive_no,
    output logic [2:0]                    state_o
);

    typedef enum logic [2:0] {
        ST_ACTIVE = 3'd0,
        ST_DRAIN  = 3'd1,
        ST_ENTER  = 3'd2,
        ST_RET    = 3'd3,
        ST_EXIT   = 3'd4
    } state_e;

    localparam logic [CntWidth-1:0] IDLE_LAST  = CntWidth'(IdleCycles - 1);
    localparam logic [CntWidth-1:0] ENTER_LAST = CntWidth'(EnterCycles - 1);
    localparam logic [CntWidth-1:0] EXIT_LAST  = CntWidth'(ExitCycles - 1);

    state_e              state_q;
    logic                set_ret_n_q;
    logic [CntWidth-1:0] idle_cnt_q;
    logic [CntWidth-1:0] settle_cnt_q;
    logic                outstanding_q;
    logic                outstanding_d;
    logic                bank_req;

    // Pass the request through only in ACTIVE. The grant is the same signal,
    // so a granted request always reaches the bank in the same cycle.
    always_comb begin
        bank_req       = bus.req_i & (state_q == ST_ACTIVE);
        bus.bank_req_o = bank_req;
        bus.gnt_o      = bank_req;
    end

    // A new request sets the outstanding flag and a response without a new request clears it.
    always_comb begin
        outstanding_d = bank_req | (outstanding_q & ~bus.rvalid_i);
    end

    // Power-sequencing FSM. Registered outputs and counters share one process.
    always_ff @(posedge clk_cg or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= ST_ACTIVE;
            set_ret_n_q   <= 1'b1;
            idle_cnt_q    <= '0;
            settle_cnt_q  <= '0;
            outstanding_q <= 1'b0;
        end else begin
            outstanding_q <= outstanding_d;
            case (state_q)
                ST_ACTIVE: begin
                    if (bus.req_i || !ret_en_i) begin
                        idle_cnt_q <= '0;
                    end else if (idle_cnt_q != IDLE_LAST) begin
                        idle_cnt_q <= idle_cnt_q + 1'b1;
                    end
                    // A live request always wins over force or idle expiry.
                    if (!bus.req_i &&
                        (force_ret_i || (ret_en_i && idle_cnt_q == IDLE_LAST))) begin
                        state_q      <= ST_DRAIN;
                        idle_cnt_q   <= '0;
                        settle_cnt_q <= '0;
                    end
                end
                ST_DRAIN: begin
                    // Leave as soon as the last access has completed. This
                    // includes the cycle in which its response arrives.
                    if (!outstanding_d) begin
                        state_q      <= ST_ENTER;
                        set_ret_n_q  <= 1'b0;
                        settle_cnt_q <= '0;
                    end
                end
                ST_ENTER: begin
                    // Entry is never aborted, even if a request shows up now.
                    if (settle_cnt_q == ENTER_LAST) begin
                        state_q      <= ST_RET;
                        settle_cnt_q <= '0;
                    end else begin
                        settle_cnt_q <= settle_cnt_q + 1'b1;
                    end
                end
                ST_RET: begin
                    if (!force_ret_i && (bus.req_i || !ret_en_i)) begin
                        state_q      <= ST_EXIT;
                        set_ret_n_q  <= 1'b1;
                        settle_cnt_q <= '0;
                    end
                end
                ST_EXIT: begin
                    if (settle_cnt_q == EXIT_LAST) begin
                        state_q      <= ST_ACTIVE;
                        settle_cnt_q <= '0;
                        idle_cnt_q   <= '0;
                    end else begin
                        settle_cnt_q <= settle_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q      <= ST_ACTIVE;
                    set_ret_n_q  <= 1'b1;
                    settle_cnt_q <= '0;
                    idle_cnt_q   <= '0;
                end
            endcase
        end
    end

    assign set_retentive_no = set_ret_n_q;
    assign state_o          = state_q;

    // A grant is only ever given to a live request.
    a_gnt_has_req: assert property (@(posedge clk_cg) disable iff (!rst_ni)
        bus.gnt_o |-> bus.req_i);

    // A response with no access in flight is treated as a bank protocol error.
    a_rvalid_expected: assert property (@(posedge clk_cg) disable iff (!rst_ni)
        bus.rvalid_i |-> outstanding_q);

    // Settling phases must run to completion.
    a_enter_complete: assert property (@(posedge clk_cg) disable iff (!rst_ni)
        (state_q == ST_ENTER && settle_cnt_q != ENTER_LAST) |=> state_q == ST_ENTER);
    a_exit_complete: assert property (@(posedge clk_cg) disable iff (!rst_ni)
        (state_q == ST_EXIT && settle_cnt_q != EXIT_LAST) |=> state_q == ST_EXIT);

    // The bank never goes retentive with an access still in flight.
    a_ret_idle: assert property (@(posedge clk_cg) disable iff (!rst_ni)
        !set_retentive_no |-> !outstanding_q);

endmodule

// File: tb/tb_sram_bank_retention_ctrl.sv
// Directed bench for sram_bank_retention_ctrl. The stimulus pushes the expected
// outputs of each cycle into a queue. A monitor on the falling edge pops the
// entries and compares them against the DUT outputs.
module tb_sram_bank_retention_ctrl;

    localparam int IDLE = 16;
    localparam int ENT  = 2;
    localparam int EXT  = 2;

    logic       clk_cg      = 1'b0;
    logic       rst_ni      = 1'b0;
    logic       ret_en_i    = 1'b0;
    logic       force_ret_i = 1'b0;
    logic       set_retentive_no;
    logic [2:0] state_o;

    sram_bank_retention_ctrl_if bus ();

    sram_bank_retention_ctrl #(
        .IdleCycles (IDLE),
        .EnterCycles(ENT),
        .ExitCycles (EXT),
        .CntWidth   (8)
    ) dut (
        .clk_cg          (clk_cg),
        .rst_ni          (rst_ni),
        .ret_en_i        (ret_en_i),
        .force_ret_i     (force_ret_i),
        .bus             (bus),
        .set_retentive_no(set_retentive_no),
        .state_o         (state_o)
    );

    always #5 clk_cg = ~clk_cg;

    int cyc = 0;
    always @(posedge clk_cg) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         cyc;
        string      nm;
        logic [2:0] st;
        logic       sr;
        logic       g;
    } exp_t;

    exp_t exp_q[$];

    function automatic void chk(string nm, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h want %0h", nm, cyc, act, exp);
        end
    endfunction

    task automatic drive(input logic r, input logic e, input logic f, input logic v);
        bus.req_i    = r;
        ret_en_i     = e;
        force_ret_i  = f;
        bus.rvalid_i = v;
    endtask

    // One clock cycle: apply the inputs, then record this cycle's expected outputs.
    task automatic step(input logic r, input logic e, input logic f, input logic v,
                        input logic [2:0] st, input logic sr, input logic g,
                        input string nm);
        @(posedge clk_cg);
        #2;
        drive(r, e, f, v);
        exp_q.push_back('{cyc, nm, st, sr, g});
    endtask

    // Monitor: compare every expectation recorded for the current cycle.
    exp_t m;
    always @(negedge clk_cg) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            m = exp_q.pop_front();
            chk({m.nm, "_cycle"}, 8'(cyc - m.cyc), 8'd0);
            chk({m.nm, "_state"}, {5'd0, state_o}, {5'd0, m.st});
            chk({m.nm, "_sret"}, {7'd0, set_retentive_no}, {7'd0, m.sr});
            chk({m.nm, "_gnt"}, {7'd0, bus.gnt_o}, {7'd0, m.g});
            chk({m.nm, "_breq"}, {7'd0, bus.bank_req_o}, {7'd0, m.g});
            $display("cycle %0d %s state=%0d sret=%0b gnt=%0b", cyc, m.nm,
                     state_o, set_retentive_no, bus.gnt_o);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        drive(1'b0, 1'b0, 1'b0, 1'b0);

        // Reset state.
        @(posedge clk_cg);
        #2;
        exp_q.push_back('{cyc, "reset", 3'd0, 1'b1, 1'b0});

        // Idle entry: release reset, and this is cycle 0 with idle count 0.
        @(posedge clk_cg);
        #2;
        rst_ni = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        exp_q.push_back('{cyc, "idle0", 3'd0, 1'b1, 1'b0});
        for (int k = 1; k < 16; k++) step(0, 1, 0, 0, 3'd0, 1'b1, 1'b0, "idle_active");
        step(0, 1, 0, 0, 3'd1, 1'b1, 1'b0, "idle_drain");  // cycle 16
        step(0, 1, 0, 0, 3'd2, 1'b0, 1'b0, "idle_enter");  // 17
        step(0, 1, 0, 0, 3'd2, 1'b0, 1'b0, "idle_enter");  // 18
        step(0, 1, 0, 0, 3'd3, 1'b0, 1'b0, "idle_ret");    // 19
        step(0, 1, 0, 0, 3'd3, 1'b0, 1'b0, "idle_ret");
        step(0, 1, 0, 0, 3'd3, 1'b0, 1'b0, "idle_ret");

        // Wake: the request is raised at t and granted at t+3.
        step(1, 1, 0, 0, 3'd3, 1'b0, 1'b0, "wake_t");
        step(1, 1, 0, 0, 3'd4, 1'b1, 1'b0, "wake_exit");
        step(1, 1, 0, 0, 3'd4, 1'b1, 1'b0, "wake_exit");
        step(1, 1, 0, 0, 3'd0, 1'b1, 1'b1, "wake_gnt");

        // Idle restart: a request pulse at idle count 10 restarts the count.
        step(0, 1, 0, 1, 3'd0, 1'b1, 1'b0, "restart_count");   // idle 0
        for (int k = 1; k < 10; k++) step(0, 1, 0, 0, 3'd0, 1'b1, 1'b0, "restart_count");
        step(1, 1, 0, 0, 3'd0, 1'b1, 1'b1, "restart_pulse");   // p, idle 10
        step(0, 1, 0, 1, 3'd0, 1'b1, 1'b0, "restart_rsp");     // p+1, idle 0
        for (int k = 2; k <= 16; k++) step(0, 1, 0, 0, 3'd0, 1'b1, 1'b0, "restart_active");
        step(0, 1, 0, 0, 3'd1, 1'b1, 1'b0, "restart_drain");   // p+17
        step(0, 1, 0, 0, 3'd2, 1'b0, 1'b0, "restart_enter");
        step(0, 1, 0, 0, 3'd2, 1'b0, 1'b0, "restart_enter");
        step(0, 1, 0, 0, 3'd3, 1'b0, 1'b0, "restart_ret");

        // Forced hold: a request does not wake the bank while force is high.
        for (int k = 0; k < 10; k++) step(1, 1, 1, 0, 3'd3, 1'b0, 1'b0, "hold_ret");
        step(1, 1, 0, 0, 3'd3, 1'b0, 1'b0, "hold_drop");       // u
        step(1, 1, 0, 0, 3'd4, 1'b1, 1'b0, "hold_exit");
        step(1, 1, 0, 0, 3'd4, 1'b1, 1'b0, "hold_exit");
        step(1, 1, 0, 0, 3'd0, 1'b1, 1'b1, "hold_gnt");        // u+3

        // Dropping ret_en mid-count clears the idle count.
        step(0, 1, 0, 1, 3'd0, 1'b1, 1'b0, "clr_count");       // c0, idle 0
        for (int k = 1; k < 8; k++) step(0, 1, 0, 0, 3'd0, 1'b1, 1'b0, "clr_count");
        step(0, 0, 0, 0, 3'd0, 1'b1, 1'b0, "clr_disable");     // c0+8
        for (int k = 9; k <= 24; k++) step(0, 1, 0, 0, 3'd0, 1'b1, 1'b0, "clr_active");
        step(0, 1, 0, 0, 3'd1, 1'b1, 1'b0, "clr_drain");       // c0+25
        step(0, 1, 0, 0, 3'd2, 1'b0, 1'b0, "clr_enter");       // c0+26

        // Reset in the middle of ENTER takes effect without waiting for a clock edge.
        @(posedge clk_cg);
        #2;
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        chk("pre_rst_state", {5'd0, state_o}, 8'd2);
        chk("pre_rst_sret", {7'd0, set_retentive_no}, 8'd0);
        #1;
        rst_ni = 1'b0;
        #1;
        chk("async_rst_state", {5'd0, state_o}, 8'd0);
        chk("async_rst_sret", {7'd0, set_retentive_no}, 8'd1);
        exp_q.push_back('{cyc, "rst_low", 3'd0, 1'b1, 1'b0});
        @(posedge clk_cg);
        #2;
        rst_ni = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        exp_q.push_back('{cyc, "rst_gnt", 3'd0, 1'b1, 1'b1});
        step(0, 0, 0, 1, 3'd0, 1'b1, 1'b0, "rst_rsp");

        // Force together with a request: the grant wins, then drain and enter retention.
        step(1, 0, 1, 0, 3'd0, 1'b1, 1'b1, "force_req");       // t
        step(0, 0, 1, 0, 3'd0, 1'b1, 1'b0, "force_wait");      // t+1
        step(0, 0, 1, 1, 3'd1, 1'b1, 1'b0, "force_drain");     // t+2
        step(0, 0, 1, 0, 3'd2, 1'b0, 1'b0, "force_enter");     // t+3
        step(0, 0, 1, 0, 3'd2, 1'b0, 1'b0, "force_enter");
        step(0, 0, 1, 0, 3'd3, 1'b0, 1'b0, "force_ret");
        step(0, 0, 0, 0, 3'd3, 1'b0, 1'b0, "force_release");   // ret_en low, wake
        step(0, 0, 0, 0, 3'd4, 1'b1, 1'b0, "force_exit");
        step(0, 0, 0, 0, 3'd4, 1'b1, 1'b0, "force_exit");
        step(0, 0, 0, 0, 3'd0, 1'b1, 1'b0, "final_active");

        repeat (2) @(posedge clk_cg);
        #2;
        chk("leftover_expectations", 8'(exp_q.size()), 8'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
